// File: rtl/sprite_mover.sv
// -----------------------------------------------------------------------------
// sprite_mover
//   Upstream stage of the VGA graphic block. Four raw push-buttons are
//   synchronised and debounced, then the sprite top-left corner (pos_x, pos_y)
//   is stepped once per accepted frame_tick. The graphic stage draws a 9x9
//   sprite from pos..pos+8, so the legal corner range is [MIN, MAX] per axis.
//
//   Optional feature: define SPRITE_WRAP_EN to make the sprite wrap around the
//   screen edges instead of saturating against them.
//
// Ports
//   clock       in   system clock, all logic on posedge
//   reset       in   synchronous, active-high reset
//   frame_tick  in   one-cycle pulse per frame, synchronous to clock
//   btn_up      in   raw async button, y -= STEP
//   btn_down    in   raw async button, y += STEP
//   btn_left    in   raw async button, x -= STEP
//   btn_right   in   raw async button, x += STEP
//   pos_x       out  registered sprite x (top-left corner)
//   pos_y       out  registered sprite y (top-left corner)
//   pos_valid   out  one-cycle pulse when pos_x/pos_y have just been updated
// -----------------------------------------------------------------------------

// Per-button front end: 2-FF synchroniser followed by a stability debouncer.
module sprite_btn_filter #(
   parameter int DEBOUNCE_CNT = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_db
);
   localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

   logic          sync1, sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // The counter measures how long the synced input has disagreed with the
   // accepted level; any agreement restarts the measurement, so only a change
   // held for DEBOUNCE_CNT consecutive cycles is accepted.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt    <= '0;
         btn_db <= 1'b0;
      end else if (sync2 == btn_db) begin
         cnt    <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt    <= '0;
         btn_db <= sync2;
      end else begin
         cnt    <= cnt + 1'b1;
      end
   end
endmodule

module sprite_mover #(
   parameter int DEBOUNCE_CNT = 500000,
   parameter int STEP         = 2,
   parameter int X_MIN        = 145,
   parameter int X_MAX        = 775,
   parameter int Y_MIN        = 36,
   parameter int Y_MAX        = 506,
   parameter int X_INIT       = 460,
   parameter int Y_INIT       = 271
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic       pos_valid
);
`ifdef SPRITE_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   localparam int NUM_BTN = 4;
   // Button lane order: [0]=up, [1]=down, [2]=left, [3]=right
   localparam int B_UP    = 0;
   localparam int B_DOWN  = 1;
   localparam int B_LEFT  = 2;
   localparam int B_RIGHT = 3;

   localparam logic [10:0] STEP11  = 11'(STEP);
   localparam logic [10:0] XMIN11  = 11'(X_MIN);
   localparam logic [10:0] XMAX11  = 11'(X_MAX);
   localparam logic [10:0] YMIN11  = 11'(Y_MIN);
   localparam logic [10:0] YMAX11  = 11'(Y_MAX);

   typedef enum logic [1:0] {
      S_WAIT    = 2'd0,
      S_MOVE_X  = 2'd1,
      S_MOVE_Y  = 2'd2,
      S_PUBLISH = 2'd3
   } state_t;

   state_t               state, state_nx;
   logic [NUM_BTN-1:0]   btn_raw, btn_db, dir;
   logic [9:0]           wx, wy;
   logic                 latch_dir, calc_x, calc_y, publish;

   assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

   // ---------------------------------------------------------------- buttons
   genvar g;
   generate
      for (g = 0; g < NUM_BTN; g++) begin : g_btn
         sprite_btn_filter #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_filt (
            .clock   (clock),
            .reset   (reset),
            .btn_raw (btn_raw[g]),
            .btn_db  (btn_db[g])
         );
      end
   endgenerate

   // One axis step. Opposing buttons cancel. The comparisons are arranged so
   // that no intermediate underflows: v > MAX-STEP instead of v+STEP > MAX and
   // v < MIN+STEP instead of v-STEP < MIN. On an edge hit the result is either
   // the same edge (clamp) or the opposite edge (wrap, remainder dropped).
   function automatic logic [9:0] step_axis(input logic [9:0]  v,
                                            input logic        neg,
                                            input logic        pos,
                                            input logic [10:0] vmin,
                                            input logic [10:0] vmax);
      logic [10:0] v11;
      logic [10:0] r;
      v11 = {1'b0, v};
      r   = v11;
      if (pos && !neg) begin
         if (v11 > vmax - STEP11) r = WRAP ? vmin : vmax;
         else                     r = v11 + STEP11;
      end else if (neg && !pos) begin
         if (v11 < vmin + STEP11) r = WRAP ? vmax : vmin;
         else                     r = v11 - STEP11;
      end
      return r[9:0];
   endfunction

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock) begin
      if (reset) state <= S_WAIT;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      latch_dir = 1'b0;
      calc_x    = 1'b0;
      calc_y    = 1'b0;
      publish   = 1'b0;
      case (state)
         S_WAIT: begin
            if (frame_tick) begin
               latch_dir = 1'b1;
               state_nx  = S_MOVE_X;
            end
         end
         S_MOVE_X: begin
            calc_x   = 1'b1;
            state_nx = S_MOVE_Y;
         end
         S_MOVE_Y: begin
            calc_y   = 1'b1;
            state_nx = S_PUBLISH;
         end
         S_PUBLISH: begin
            publish  = 1'b1;
            state_nx = S_WAIT;
         end
         default: state_nx = S_WAIT;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   // Directions are frozen at the tick so button activity during the update
   // cannot tear the move between the two axes.
   always_ff @(posedge clock) begin
      if (reset) begin
         dir       <= '0;
         wx        <= 10'(X_INIT);
         wy        <= 10'(Y_INIT);
         pos_x     <= 10'(X_INIT);
         pos_y     <= 10'(Y_INIT);
         pos_valid <= 1'b0;
      end else begin
         pos_valid <= publish;
         if (latch_dir) dir <= btn_db;
         if (calc_x)
            wx <= step_axis(pos_x, dir[B_LEFT], dir[B_RIGHT], XMIN11, XMAX11);
         if (calc_y)
            wy <= step_axis(pos_y, dir[B_UP], dir[B_DOWN], YMIN11, YMAX11);
         if (publish) begin
            pos_x <= wx;
            pos_y <= wy;
         end
      end
   end
endmodule

// File: tb/tb_sprite_mover.sv
// -----------------------------------------------------------------------------
// tb_sprite_mover
//   Directed, table-driven bench for sprite_mover with DEBOUNCE_CNT=4.
//   Inputs change 1 ns after a rising edge; outputs are sampled at the same
//   point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_sprite_mover;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic [9:0] pos_x, pos_y;
   logic       pos_valid;

   int n_tests = 0;
   int n_fail  = 0;

   always #10 clock = ~clock;

   sprite_mover #(.DEBOUNCE_CNT(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .frame_tick (frame_tick),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .pos_valid  (pos_valid)
   );

   // {inputs, expected outputs}; btn = {right, left, down, up}
   typedef struct {
      logic [3:0] btn;
      int         ex;
      int         ey;
   } vec_t;

   vec_t tv [8];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_btn(input logic [3:0] b);
      {btn_right, btn_left, btn_down, btn_up} = b;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      frame_tick = 1'b0;
      steps(2);
      reset      = 1'b0;
   endtask

   // One tick with full timing check: valid must rise exactly on the third
   // edge after the tick is sampled and drop on the fourth.
   task automatic tick_chk(input string nm, input int ex, input int ey);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step(); chk({nm, " valid@1"}, int'(pos_valid), 0);
      step(); chk({nm, " valid@2"}, int'(pos_valid), 0);
      step(); chk({nm, " valid@3"}, int'(pos_valid), 1);
              chk({nm, " pos_x"},   int'(pos_x), ex);
              chk({nm, " pos_y"},   int'(pos_y), ey);
      step(); chk({nm, " valid@4"}, int'(pos_valid), 0);
   endtask

   // Unchecked ticks used to walk the sprite toward an edge.
   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         steps(4);
      end
   endtask

   task automatic count_valid(input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (pos_valid) c++;
      end
   endtask

   initial begin
      int c;

      tv[0] = '{4'b0000, 460, 271};   // no buttons
      tv[1] = '{4'b1000, 462, 271};   // right
      tv[2] = '{4'b1000, 464, 271};
      tv[3] = '{4'b1000, 466, 271};
      tv[4] = '{4'b1011, 468, 271};   // right + up + down: y cancels
      tv[5] = '{4'b1101, 468, 269};   // right + left + up: x cancels
      tv[6] = '{4'b0110, 466, 271};   // left + down: diagonal
      tv[7] = '{4'b1111, 466, 271};   // everything cancels

      // reset state
      do_reset();
      chk("reset pos_x", int'(pos_x), 460);
      chk("reset pos_y", int'(pos_y), 271);
      chk("reset valid", int'(pos_valid), 0);

      // table: buttons settle well past the debounce window, then one tick
      for (int i = 0; i < 8; i++) begin
         set_btn(tv[i].btn);
         steps(8);
         tick_chk($sformatf("vec%0d", i), tv[i].ex, tv[i].ey);
      end

      // debounce: 3-cycle glitch rejected, 4-cycle press accepted
      set_btn(4'b0000);
      steps(10);
      set_btn(4'b1000); steps(3); set_btn(4'b0000);
      steps(10);
      tick_chk("glitch3", 466, 271);
      set_btn(4'b1000); steps(4); set_btn(4'b0000);
      steps(2);
      tick_chk("press4", 468, 271);
      steps(10);

      // x edge behaviour
      do_reset();
`ifdef SPRITE_WRAP_EN
      set_btn(4'b0100); steps(8);
      tick_n(157);
      chk("walk to 146", int'(pos_x), 146);
      tick_n(1);
      chk("wrap left", int'(pos_x), 775);
      tick_n(314);
      chk("walk to 147", int'(pos_x), 147);
      tick_chk("xedge t1", 145, 271);
      tick_chk("xedge t2", 775, 271);
      tick_chk("xedge t3", 773, 271);
`else
      set_btn(4'b1000); steps(8);
      tick_n(158);
      chk("clamp right", int'(pos_x), 775);
      set_btn(4'b0100); steps(8);
      tick_n(314);
      chk("walk to 147", int'(pos_x), 147);
      tick_chk("xedge t1", 145, 271);
      tick_chk("xedge t2", 145, 271);
      tick_chk("xedge t3", 145, 271);
`endif

      // y top edge
      set_btn(4'b0000);
      do_reset();
      set_btn(4'b0001); steps(8);
      tick_n(117);
      chk("walk to y37", int'(pos_y), 37);
      tick_chk("yedge t1", 460, 36);
`ifdef SPRITE_WRAP_EN
      tick_chk("yedge t2", 460, 506);
`else
      tick_chk("yedge t2", 460, 36);
`endif

      // tick while busy is ignored: tick held through S_WAIT and S_MOVE_X
      set_btn(4'b0000);
      do_reset();
      set_btn(4'b1000); steps(8);
      frame_tick = 1'b1;
      steps(2);
      frame_tick = 1'b0;
      count_valid(8, c);
      chk("busy tick pulses", c, 1);
      chk("busy tick pos_x", int'(pos_x), 462);

      // reset during S_MOVE_Y aborts the update
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      count_valid(6, c);
      chk("abort pulses", c, 0);
      chk("abort pos_x", int'(pos_x), 460);
      chk("abort pos_y", int'(pos_y), 271);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
